sram_2rw_param: RTL and testbench
=================================

Name: sram_2rw_param

Overview:
- Parametrised, synthesisable-style behavioural model of a true dual-port (2RW) SRAM macro for the lxp32 SoC memory subsystem.
- Successor to the fixed 128x32 dual-port model. Adds:
  - configurable width and depth;
  - byte-write enables;
  - a single shared clock;
  - a defined cross-port collision policy;
  - a post-reset hardware clear sequence with a ready flag.
- Instantiated under the instruction/data RAM wrappers.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8; BYTES = DATA_W/8.
- DEPTH, 128: number of words; need not be a power of two.
- ADDR_W, 7: address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk_i  in  1  single clock for both ports (rising edge).
- rstn_i  in  1  asynchronous, active-low reset.
- ready_o  out  1  high once the post-reset clear has completed.
- collision_o  out  1  one-cycle pulse: same-address access on both ports with at least one write.
- csb_a_i  in  1  port A chip select, active low.
- web_a_i  in  1  port A write enable, active low (1 = read).
- oeb_a_i  in  1  port A output enable, active low.
- addr_a_i  in  ADDR_W  port A word address.
- wdata_a_i  in  DATA_W  port A write data.
- bwe_a_i  in  BYTES  port A byte write enables, active high.
- rdata_a_o  out  DATA_W  port A read data.
- csb_b_i, web_b_i, oeb_b_i, addr_b_i, wdata_b_i, bwe_b_i, rdata_b_o: identical to the port A signals, for port B.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (rstn_i).
- Reset state (asserted anywhere, including mid-clear):
  - FSM = CLEAR, clear counter = 0;
  - ready_o = 0, collision_o = 0;
  - read registers for both ports = 0.
  - Array contents are not reset asynchronously.
- FSM CLEAR:
  - Each cycle writes all-zero to word[counter], then increments the counter.
  - After writing word DEPTH-1, moves to READY.
  - ready_o rises on the edge after the last clear write: exactly DEPTH cycles after reset release.
  - All port requests are ignored while in CLEAR: no writes, read registers hold 0, collision_o stays 0.
- FSM READY: terminal state; left only via reset.
- Access: a port is active on a rising edge when its csb is 0.
  - Read (web = 1): read register loads word[addr]; visible on rdata the next cycle (latency 1).
  - Write (web = 0): for each byte i with bwe[i] = 1, word[addr] byte i <- wdata byte i. Bytes with bwe[i] = 0 are unchanged. The port's read register holds its previous value.
  - Inactive port (csb = 1): read register holds its value.
- Out of range (addr >= DEPTH): write is dropped; read loads 0.
- Output enable: rdata = read register when oeb = 0, all-zero when oeb = 1. This is combinational and does not disturb the register. Rdata is never driven to z.
- Cross-port, same address, same edge:
  - Read vs write: the reading port gets the old data (read-first). The write completes.
  - Write vs write: for bytes enabled on both ports, port A wins. Bytes enabled on only one port take that port's data.
  - Read vs read: both ports get the same data; no collision.
  - collision_o = 1 for the cycle after any read-vs-write or write-vs-write collision, otherwise 0. Evaluated only in READY and only for in-range addresses.
- Back-to-back: a write followed by a read of the same address on the next cycle, from either port, returns the new data.

Optional Feature:
- Macro: SRAM2RW_OUTREG_EN.
- Defined:
  - Each port gains a second output pipeline register, fed from the read register every cycle.
  - Read latency becomes 2; a write cycle still holds stage 1, so stage 2 repeats the held value.
  - Both stages reset to 0.
  - oeb gating applies after stage 2.
  - collision_o timing is unchanged (1 cycle).
- Undefined: single read register; latency 1 as above.

Test Plan:
- Reset release with DEPTH = 128 -> ready_o = 0 for 128 cycles, then 1. Writes issued during the clear are ignored. Reads afterwards of addr 0x00, 0x3F and 0x7F return 0x00000000.
- Port A writes 0xDEADBEEF to addr 5 with bwe = 4'b1111; next cycle port B reads addr 5 -> rdata_b_o = 0xDEADBEEF one cycle later. With oeb_b_i = 1 -> rdata_b_o = 0x00000000.
- Addr 9 = 0x11223344; port A writes 0xAABBCCDD with bwe = 4'b0101 -> a subsequent read returns 0x11BB33DD.
- Same edge: A writes 0x12345678 to addr 3 while B reads addr 3 (old value 0) -> rdata_b_o = 0, collision_o = 1 for one cycle. Next read of addr 3 = 0x12345678.
- Same edge: A writes 0xAAAAAAAA with bwe = 4'b0011 and B writes 0xBBBBBBBB with bwe = 4'b0110 to addr 7 (old 0) -> word = 0x00BBAAAA, collision_o pulses.
- DEPTH = 100: write to addr 120, then read addr 120 -> 0. Assert rstn_i mid-clear at cycle 50 -> ready_o stays 0 until 100 cycles after the second release. With SRAM2RW_OUTREG_EN, read latency measured = 2.

Source files
------------

// File: rtl/sram_2rw_param.sv
`timescale 1ns/1ps
// True dual-port (2RW) SRAM model with byte write enables, read-first collisions and a zero-fill sequence after reset.
// Define SRAM2RW_OUTREG_EN to add a second output register per port (read latency 2).
module sram_2rw_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  output logic                ready_o,
  output logic                collision_o,
  input  logic                csb_a_i,
  input  logic                web_a_i,
  input  logic                oeb_a_i,
  input  logic [ADDR_W-1:0]   addr_a_i,
  input  logic [DATA_W-1:0]   wdata_a_i,
  input  logic [DATA_W/8-1:0] bwe_a_i,
  output logic [DATA_W-1:0]   rdata_a_o,
  input  logic                csb_b_i,
  input  logic                web_b_i,
  input  logic                oeb_b_i,
  input  logic [ADDR_W-1:0]   addr_b_i,
  input  logic [DATA_W-1:0]   wdata_b_i,
  input  logic [DATA_W/8-1:0] bwe_b_i,
  output logic [DATA_W-1:0]   rdata_b_o
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = DEPTH[ADDR_W:0];

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              clr_we;
  logic              collision_reg, collision_next;

  logic a_ok, b_ok, act_a, act_b, wr_a, wr_b, rd_a, rd_b;
  wire  [DATA_W-1:0] rd_a_q, rd_b_q;
  logic [DATA_W-1:0] data_a, data_b;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= S_CLEAR;
      clr_cnt_reg   <= '0;
      collision_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      collision_reg <= collision_next;
    end
  end

  // Zero-fill walks the array once, then the FSM parks in READY until the next reset.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    clr_we       = 1'b0;
    case (state_reg)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_reg == LAST_ADDR) state_next = S_READY;
        else                          clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign ready_o     = (state_reg == S_READY);
  assign collision_o = collision_reg;

  assign a_ok  = ({1'b0, addr_a_i} < DEPTH_W);
  assign b_ok  = ({1'b0, addr_b_i} < DEPTH_W);
  assign act_a = ready_o && !csb_a_i;
  assign act_b = ready_o && !csb_b_i;
  assign wr_a  = act_a && !web_a_i && a_ok;
  assign wr_b  = act_b && !web_b_i && b_ok;
  assign rd_a  = act_a && web_a_i;
  assign rd_b  = act_b && web_b_i;

  assign collision_next = act_a && act_b && a_ok && b_ok &&
                          (addr_a_i == addr_b_i) && (!web_a_i || !web_b_i);

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_a_reg, rd_b_reg;

    // Port A is written last so it wins bytes enabled on both ports.
    always_ff @(posedge clk_i) begin
      if (clr_we) begin
        lane_mem[clr_cnt_reg] <= '0;
      end else begin
        if (wr_b && bwe_b_i[gi]) lane_mem[addr_b_i] <= wdata_b_i[gi*8 +: 8];
        if (wr_a && bwe_a_i[gi]) lane_mem[addr_a_i] <= wdata_a_i[gi*8 +: 8];
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        rd_a_reg <= '0;
        rd_b_reg <= '0;
      end else begin
        if (rd_a) rd_a_reg <= a_ok ? lane_mem[addr_a_i] : 8'h00;
        if (rd_b) rd_b_reg <= b_ok ? lane_mem[addr_b_i] : 8'h00;
      end
    end

    assign rd_a_q[gi*8 +: 8] = rd_a_reg;
    assign rd_b_q[gi*8 +: 8] = rd_b_reg;
  end

`ifdef SRAM2RW_OUTREG_EN
  logic [DATA_W-1:0] out_a_reg, out_b_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_a_reg <= '0;
      out_b_reg <= '0;
    end else begin
      out_a_reg <= rd_a_q;
      out_b_reg <= rd_b_q;
    end
  end

  assign data_a = out_a_reg;
  assign data_b = out_b_reg;
`else
  assign data_a = rd_a_q;
  assign data_b = rd_b_q;
`endif

  assign rdata_a_o = oeb_a_i ? '0 : data_a;
  assign rdata_b_o = oeb_b_i ? '0 : data_b;

endmodule

// File: tb/tb_sram_2rw_param.sv
`timescale 1ns/1ps
// Directed bench for sram_2rw_param: one DUT with DEPTH=128 and one with DEPTH=100 share all stimulus.
module tb_sram_2rw_param;

`ifdef SRAM2RW_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        csb_a, web_a, oeb_a, csb_b, web_b, oeb_b;
  logic [6:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [3:0]  bwe_a, bwe_b;
  logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic        ready0, ready1, coll0, coll1;

  int n_vec = 0;
  int n_err = 0;

  sram_2rw_param #(.DATA_W(32), .DEPTH(128), .ADDR_W(7)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .ready_o(ready0), .collision_o(coll0),
    .csb_a_i(csb_a), .web_a_i(web_a), .oeb_a_i(oeb_a), .addr_a_i(addr_a),
    .wdata_a_i(wdata_a), .bwe_a_i(bwe_a), .rdata_a_o(rdata_a0),
    .csb_b_i(csb_b), .web_b_i(web_b), .oeb_b_i(oeb_b), .addr_b_i(addr_b),
    .wdata_b_i(wdata_b), .bwe_b_i(bwe_b), .rdata_b_o(rdata_b0)
  );

  sram_2rw_param #(.DATA_W(32), .DEPTH(100), .ADDR_W(7)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .ready_o(ready1), .collision_o(coll1),
    .csb_a_i(csb_a), .web_a_i(web_a), .oeb_a_i(oeb_a), .addr_a_i(addr_a),
    .wdata_a_i(wdata_a), .bwe_a_i(bwe_a), .rdata_a_o(rdata_a1),
    .csb_b_i(csb_b), .web_b_i(web_b), .oeb_b_i(oeb_b), .addr_b_i(addr_b),
    .wdata_b_i(wdata_b), .bwe_b_i(bwe_b), .rdata_b_o(rdata_b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb_a = 1'b1; web_a = 1'b1; oeb_a = 1'b0; addr_a = '0; wdata_a = '0; bwe_a = '0;
    csb_b = 1'b1; web_b = 1'b1; oeb_b = 1'b0; addr_b = '0; wdata_b = '0; bwe_b = '0;
  endtask

  task automatic set_a(input logic we_n, input logic [6:0] addr, input logic [31:0] d, input logic [3:0] be);
    csb_a = 1'b0; web_a = we_n; addr_a = addr; wdata_a = d; bwe_a = be;
  endtask

  task automatic set_b(input logic we_n, input logic [6:0] addr, input logic [31:0] d, input logic [3:0] be);
    csb_b = 1'b0; web_b = we_n; addr_b = addr; wdata_b = d; bwe_b = be;
  endtask

  // Apply the staged access on one edge, then return both ports to idle.
  task automatic issue();
    tick();
    idle();
  endtask

  // Extra edges so a read issued by issue() has reached rdata.
  task automatic settle();
    repeat (LAT - 1) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0, t1;
    bit  coll_seen, rd_seen;

    rstn = 1'b0;
    idle();
    repeat (3) tick();
    check("reset ready0", {31'b0, ready0}, 32'h0);
    check("reset ready1", {31'b0, ready1}, 32'h0);
    check("reset coll0", {31'b0, coll0}, 32'h0);
    check("reset rdata_a0", rdata_a0, 32'h0);
    check("reset rdata_b1", rdata_b1, 32'h0);

    // First clear is interrupted at cycle 50; port traffic during the clear must be ignored.
    rstn = 1'b1;
    set_a(1'b0, 7'h3F, 32'hFFFF_FFFF, 4'hF);
    set_b(1'b1, 7'h3F, 32'h0, 4'h0);
    repeat (50) tick();
    check("mid-clear ready1", {31'b0, ready1}, 32'h0);
    rstn = 1'b0;
    #2;
    rstn = 1'b1;

    t0 = 0; t1 = 0; coll_seen = 1'b0; rd_seen = 1'b0;
    for (int t = 1; t <= 300 && t0 == 0; t++) begin
      tick();
      if (t1 == 0) begin
        coll_seen = coll_seen | coll0 | coll1;
        rd_seen   = rd_seen | (rdata_b0 != 0) | (rdata_b1 != 0);
      end
      if (ready1 && t1 == 0) begin
        t1 = t;
        idle();
      end
      if (ready0 && t0 == 0) t0 = t;
    end
    check("clear cycles DEPTH=100", t1, 32'd100);
    check("clear cycles DEPTH=128", t0, 32'd128);
    check("no collision in clear", {31'b0, coll_seen}, 32'h0);
    check("rdata zero in clear", {31'b0, rd_seen}, 32'h0);

    // Cleared contents, including the word targeted during the clear.
    set_a(1'b1, 7'h00, 32'h0, 4'h0);
    set_b(1'b1, 7'h3F, 32'h0, 4'h0);
    issue(); settle();
    check("clr rd 0x00 a0", rdata_a0, 32'h0);
    check("clr rd 0x3F b0", rdata_b0, 32'h0);
    check("clr rd 0x3F b1", rdata_b1, 32'h0);
    set_a(1'b1, 7'h7F, 32'h0, 4'h0);
    issue(); settle();
    check("clr rd 0x7F a0", rdata_a0, 32'h0);

    // Write on A, read back on B the next cycle, then output-enable gating.
    set_a(1'b0, 7'd5, 32'hDEAD_BEEF, 4'hF);
    issue();
    set_b(1'b1, 7'd5, 32'h0, 4'h0);
    issue(); settle();
    check("b2b A->B b0", rdata_b0, 32'hDEAD_BEEF);
    check("b2b A->B b1", rdata_b1, 32'hDEAD_BEEF);
    oeb_b = 1'b1;
    #1;
    check("oeb_b=1 b0", rdata_b0, 32'h0);
    oeb_b = 1'b0;
    #1;
    check("oeb_b=0 b0", rdata_b0, 32'hDEAD_BEEF);

    // Partial byte write.
    set_a(1'b0, 7'd9, 32'h1122_3344, 4'hF);
    issue();
    set_a(1'b0, 7'd9, 32'hAABB_CCDD, 4'b0101);
    issue();
    set_a(1'b1, 7'd9, 32'h0, 4'h0);
    issue(); settle();
    check("bwe 0101 a0", rdata_a0, 32'h11BB_33DD);
    check("bwe 0101 a1", rdata_a1, 32'h11BB_33DD);

    // A writes while B reads the same word: B sees old data (0), replacing its held DEADBEEF.
    set_a(1'b0, 7'd3, 32'h1234_5678, 4'hF);
    set_b(1'b1, 7'd3, 32'h0, 4'h0);
    issue();
    check("rw coll0 pulse", {31'b0, coll0}, 32'h1);
    check("rw coll1 pulse", {31'b0, coll1}, 32'h1);
    settle();
    check("rw read-first b0", rdata_b0, 32'h0);
    tick();
    check("rw coll0 cleared", {31'b0, coll0}, 32'h0);
    set_a(1'b1, 7'd3, 32'h0, 4'h0);
    issue(); settle();
    check("rw write done a0", rdata_a0, 32'h1234_5678);

    // B writes while A reads a non-zero word.
    set_b(1'b0, 7'd5, 32'h0BAD_F00D, 4'hF);
    set_a(1'b1, 7'd5, 32'h0, 4'h0);
    issue();
    check("wr coll0 pulse", {31'b0, coll0}, 32'h1);
    settle();
    check("wr read-first a0", rdata_a0, 32'hDEAD_BEEF);
    set_b(1'b1, 7'd5, 32'h0, 4'h0);
    issue(); settle();
    check("wr write done b0", rdata_b0, 32'h0BAD_F00D);

    // Write vs write with overlapping byte enables.
    set_a(1'b0, 7'd7, 32'hAAAA_AAAA, 4'b0011);
    set_b(1'b0, 7'd7, 32'hBBBB_BBBB, 4'b0110);
    issue();
    check("ww coll0 pulse", {31'b0, coll0}, 32'h1);
    set_a(1'b1, 7'd7, 32'h0, 4'h0);
    set_b(1'b1, 7'd7, 32'h0, 4'h0);
    issue();
    check("rr no coll0", {31'b0, coll0}, 32'h0);
    settle();
    check("ww merge a0", rdata_a0, 32'h00BB_AAAA);
    check("ww merge b1", rdata_b1, 32'h00BB_AAAA);

    // A write cycle leaves the port's read data unchanged.
    set_a(1'b0, 7'd7, 32'h0000_0001, 4'hF);
    issue(); settle();
    check("write holds a0", rdata_a0, 32'h00BB_AAAA);

    // Range boundary: addr 99 is the last word of DUT1, addr 120 is outside it.
    set_b(1'b0, 7'd99, 32'h9999_9999, 4'hF);
    issue();
    set_a(1'b1, 7'd99, 32'h0, 4'h0);
    issue(); settle();
    check("last word a1", rdata_a1, 32'h9999_9999);
    set_a(1'b0, 7'd120, 32'hCAFE_F00D, 4'hF);
    set_b(1'b0, 7'd120, 32'h5555_5555, 4'hF);
    issue();
    check("oor ww coll0", {31'b0, coll0}, 32'h1);
    check("oor ww coll1", {31'b0, coll1}, 32'h0);
    set_a(1'b1, 7'd120, 32'h0, 4'h0);
    set_b(1'b1, 7'd20, 32'h0, 4'h0);
    issue(); settle();
    check("oor rd 120 a0", rdata_a0, 32'hCAFE_F00D);
    check("oor rd 120 a1", rdata_a1, 32'h0);
    check("no alias 20 b1", rdata_b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
